// File: rtl/apb_reg_completer_if.sv
// apb_reg_completer_if: APB signal bundle between a requester and the register completer
interface apb_reg_completer_if #(
  parameter int addrWidth = 12
);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [addrWidth-1:0] paddr;
  logic [31:0]          pwdata;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB register bank with programmable wait states, error flagging and a transfer counter
module apb_reg_completer #(
  parameter int addrWidth   = 12,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic                i_pclk,
  input logic                i_presetn,
  apb_reg_completer_if.slave io_apb
);
  localparam int IW   = addrWidth - 2;
  localparam int RW   = $clog2(NUM_REGS);
  localparam int LAST = NUM_REGS - 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;
  state_t        r_state, w_state_nxt;
  logic [3:0]    r_wcnt, w_wcnt_nxt, w_wcnt_inc;
  logic          r_write, r_err, r_pready, r_pslverr;
  logic          w_setup, w_latch, w_commit, w_go_ready, w_err_new, w_err_sel, w_write_sel;
  logic [IW-1:0] w_idx;
  logic [RW-1:0] r_idx, w_idx_sel;
  logic [31:0]   r_regs [LAST];
  logic [31:0]   r_cnt, r_prdata, w_rd_val;
  assign w_idx      = io_apb.paddr[addrWidth-1:2];
  assign w_setup    = io_apb.psel & ~io_apb.penable;
  assign w_err_new  = (io_apb.paddr[1:0] != 2'b00) || (int'(w_idx) >= NUM_REGS) ||
                      (io_apb.pwrite && int'(w_idx) == LAST);
  assign w_wcnt_inc = r_wcnt + 4'd1;
  // with zero wait states READY follows setup directly, so the live request feeds the response
  assign w_err_sel   = w_latch ? w_err_new : r_err;
  assign w_write_sel = w_latch ? io_apb.pwrite : r_write;
  assign w_idx_sel   = w_latch ? w_idx[RW-1:0] : r_idx;
  assign w_rd_val    = (w_idx_sel == RW'(LAST)) ? r_cnt : r_regs[w_idx_sel];
  assign w_go_ready  = (w_state_nxt == S_READY);
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: w_latch = w_setup;
      S_WAIT: begin
        if (!io_apb.psel) w_state_nxt = S_IDLE;
        else if (io_apb.penable) begin
          w_wcnt_nxt  = w_wcnt_inc;
          w_state_nxt = (w_wcnt_inc == 4'(WAIT_CYCLES)) ? S_READY : S_WAIT;
        end
      end
      S_READY: begin
        w_commit    = io_apb.psel & io_apb.penable;
        w_latch     = w_setup;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_latch) begin
      w_state_nxt = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
      w_wcnt_nxt  = '0;
    end
  end
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      for (int i = 0; i < LAST; i++) r_regs[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_pready  <= w_go_ready;
      r_pslverr <= w_go_ready & w_err_sel;
      r_prdata  <= (w_go_ready && !w_err_sel && !w_write_sel) ? w_rd_val : '0;
      if (w_latch) begin
        r_write <= io_apb.pwrite;
        r_err   <= w_err_new;
        r_idx   <= w_idx[RW-1:0];
      end
      if (w_commit && !r_err) begin
        if (r_write) r_regs[r_idx] <= io_apb.pwdata;
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end
  assign io_apb.pready  = r_pready;
  assign io_apb.pslverr = r_pslverr;
  assign io_apb.prdata  = r_prdata;
endmodule

// File: tb/tb_apb_reg_completer.sv
// tb_apb_reg_completer: directed tables plus randomized transfers against a register-map model, on a 2-wait and a 0-wait instance
module tb_apb_reg_completer;
  logic        clk = 1'b0;
  logic        presetn = 1'b1;
  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [11:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];
  int passed = 0;
  int total = 0;
  logic [31:0] mem [2][15];
  logic [31:0] cnt [2];
  typedef struct {
    int          d;
    bit          wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          er;
  } vec_t;
  vec_t tv [15];
  always #5 clk = ~clk;
  apb_reg_completer_if #(.addrWidth(12)) bus0 ();
  apb_reg_completer_if #(.addrWidth(12)) bus1 ();
  assign bus0.psel = psel[0];
  assign bus0.penable = penable[0];
  assign bus0.pwrite = pwrite[0];
  assign bus0.paddr = paddr[0];
  assign bus0.pwdata = pwdata[0];
  assign bus1.psel = psel[1];
  assign bus1.penable = penable[1];
  assign bus1.pwrite = pwrite[1];
  assign bus1.paddr = paddr[1];
  assign bus1.pwdata = pwdata[1];
  assign prdata[0] = bus0.prdata;
  assign pready[0] = bus0.pready;
  assign pslverr[0] = bus0.pslverr;
  assign prdata[1] = bus1.prdata;
  assign pready[1] = bus1.pready;
  assign pslverr[1] = bus1.pslverr;
  apb_reg_completer #(.addrWidth(12), .NUM_REGS(16), .WAIT_CYCLES(2)) u_dut0 (
    .i_pclk(clk), .i_presetn(presetn), .io_apb(bus0));
  apb_reg_completer #(.addrWidth(12), .NUM_REGS(16), .WAIT_CYCLES(0)) u_dut1 (
    .i_pclk(clk), .i_presetn(presetn), .io_apb(bus1));
  function automatic int waits(input int d);
    return (d == 0) ? 2 : 0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic bit m_err(input bit wr, input logic [11:0] a);
    return (a[1:0] != 2'b00) || (a[11:2] >= 10'd16) || (wr && a[11:2] == 10'd15);
  endfunction
  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      for (int i = 0; i < 15; i++) mem[d][i] = 0;
    end
  endtask
  task automatic m_apply(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit er);
    er = m_err(wr, a);
    rd = 0;
    if (!er) begin
      if (!wr) rd = (a[11:2] == 10'd15) ? cnt[d] : mem[d][a[5:2]];
      else mem[d][a[5:2]] = wd;
      cnt[d] = cnt[d] + 1;
    end
  endtask
  // complete one transfer starting at a negedge; returns at the negedge after the pready cycle
  task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_er, input string tag);
    int n;
    bit seen;
    psel[d] = 1'b1;
    penable[d] = 1'b0;
    pwrite[d] = wr;
    paddr[d] = a;
    pwdata[d] = wd;
    @(negedge clk);
    penable[d] = 1'b1;
    paddr[d] = 12'($urandom);
    pwrite[d] = ~wr;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      n++;
      if (pready[d]) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, " latency"}, 32'(n), 32'(waits(d) + 1));
    chk({tag, " prdata"}, prdata[d], exp_rd);
    chk({tag, " pslverr"}, {31'b0, pslverr[d]}, {31'b0, exp_er});
    @(negedge clk);
    psel[d] = 1'b0;
    penable[d] = 1'b0;
    chk({tag, " after"}, prdata[d] | {30'b0, pready[d], pslverr[d]}, 32'h0);
  endtask
  task automatic abort0(input logic [11:0] a, input string tag);
    bit seen;
    psel[0] = 1'b1;
    penable[0] = 1'b0;
    pwrite[0] = 1'b1;
    paddr[0] = a;
    pwdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    penable[0] = 1'b1;
    seen = pready[0];
    @(negedge clk);
    seen |= pready[0];
    psel[0] = 1'b0;
    penable[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen |= pready[0];
    end
    chk({tag, " pready"}, {31'b0, seen}, 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    bit er, wr;
    int d, idx, low, gap;
    logic [11:0] a;
    logic [31:0] wd;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0;
      penable[i] = 1'b0;
      pwrite[i] = 1'b0;
      paddr[i] = '0;
      pwdata[i] = '0;
    end
    tv[0]  = '{0, 1'b1, 12'h004, 32'hDEADBEEF, 32'h0, 1'b0};
    tv[1]  = '{0, 1'b0, 12'h004, 32'h0, 32'hDEADBEEF, 1'b0};
    tv[2]  = '{0, 1'b0, 12'h03C, 32'h0, 32'd2, 1'b0};
    tv[3]  = '{0, 1'b1, 12'h031, 32'hAAAA5555, 32'h0, 1'b1};
    tv[4]  = '{0, 1'b1, 12'h03C, 32'h12345678, 32'h0, 1'b1};
    tv[5]  = '{0, 1'b0, 12'h040, 32'h0, 32'h0, 1'b1};
    tv[6]  = '{0, 1'b0, 12'h030, 32'h0, 32'h0, 1'b0};
    tv[7]  = '{0, 1'b0, 12'h03C, 32'h0, 32'd4, 1'b0};
    tv[8]  = '{1, 1'b1, 12'h000, 32'h11111111, 32'h0, 1'b0};
    tv[9]  = '{1, 1'b1, 12'h008, 32'h22222222, 32'h0, 1'b0};
    tv[10] = '{1, 1'b1, 12'h010, 32'h33333333, 32'h0, 1'b0};
    tv[11] = '{1, 1'b0, 12'h000, 32'h0, 32'h11111111, 1'b0};
    tv[12] = '{1, 1'b0, 12'h008, 32'h0, 32'h22222222, 1'b0};
    tv[13] = '{1, 1'b0, 12'h010, 32'h0, 32'h33333333, 1'b0};
    tv[14] = '{1, 1'b0, 12'h03C, 32'h0, 32'd6, 1'b0};
    #2 presetn = 1'b0;
    #1;
    chk("reset outputs dut0", prdata[0] | {30'b0, pready[0], pslverr[0]}, 32'h0);
    chk("reset outputs dut1", prdata[1] | {30'b0, pready[1], pslverr[1]}, 32'h0);
    repeat (3) @(negedge clk);
    presetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++)
      xfer(tv[i].d, tv[i].wr, tv[i].a, tv[i].wd, tv[i].rd, tv[i].er, $sformatf("vec%0d", i));
    abort0(12'h00C, "abort");
    xfer(0, 1'b0, 12'h00C, 32'h0, 32'h0, 1'b0, "abort readback");
    psel[0] = 1'b1;
    penable[0] = 1'b0;
    pwrite[0] = 1'b1;
    paddr[0] = 12'h008;
    pwdata[0] = 32'h55;
    @(negedge clk);
    penable[0] = 1'b1;
    @(negedge clk);
    psel[1] = 1'b1;
    penable[1] = 1'b0;
    pwrite[1] = 1'b0;
    paddr[1] = 12'h000;
    @(negedge clk);
    penable[1] = 1'b1;
    chk("midrst pre pready0", {31'b0, pready[0]}, 32'h1);
    chk("midrst pre prdata1", prdata[1], 32'h11111111);
    #1 presetn = 1'b0;
    #1;
    chk("midrst pready0", {31'b0, pready[0]}, 32'h0);
    chk("midrst pready1", {31'b0, pready[1]}, 32'h0);
    chk("midrst prdata1", prdata[1], 32'h0);
    chk("midrst pslverr", {30'b0, pslverr[0], pslverr[1]}, 32'h0);
    psel[0] = 1'b0;
    penable[0] = 1'b0;
    psel[1] = 1'b0;
    penable[1] = 1'b0;
    @(negedge clk);
    presetn = 1'b1;
    @(negedge clk);
    xfer(0, 1'b0, 12'h008, 32'h0, 32'h0, 1'b0, "post rst 008");
    xfer(0, 1'b0, 12'h004, 32'h0, 32'h0, 1'b0, "post rst 004");
    xfer(1, 1'b0, 12'h000, 32'h0, 32'h0, 1'b0, "post rst dut1 000");
    xfer(0, 1'b0, 12'h03C, 32'h0, 32'd2, 1'b0, "post rst cnt");
    force u_dut0.r_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_dut0.r_cnt;
    xfer(0, 1'b0, 12'h03C, 32'h0, 32'hFFFF_FFFF, 1'b0, "wrap max");
    xfer(0, 1'b0, 12'h03C, 32'h0, 32'h0, 1'b0, "wrap zero");
    presetn = 1'b0;
    @(negedge clk);
    presetn = 1'b1;
    m_reset();
    @(negedge clk);
    for (int k = 0; k < 160; k++) begin
      d = $urandom_range(0, 1);
      wr = 1'($urandom);
      idx = $urandom_range(0, 17);
      low = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      a = {idx[9:0], low[1:0]};
      wd = $urandom;
      if (d == 0 && $urandom_range(0, 9) == 0) abort0(a, $sformatf("rnd%0d abort", k));
      else begin
        m_apply(d, wr, a, wd, rd, er);
        xfer(d, wr, a, wd, rd, er, $sformatf("rnd%0d", k));
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
    for (int d2 = 0; d2 < 2; d2++)
      for (int i = 0; i < 16; i++) begin
        m_apply(d2, 1'b0, 12'(i * 4), 32'h0, rd, er);
        xfer(d2, 1'b0, 12'(i * 4), 32'h0, rd, er, $sformatf("final dut%0d reg%0d", d2, i));
      end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
